// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int unsigned DMEM_ADDR_W = 20;
  localparam int unsigned DMEM_DATA_W = 32;
  localparam int unsigned DMEM_BE_W   = DMEM_DATA_W / 8;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_RESP = 2'd2
  } dm_state_t;

  typedef struct packed {
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
    logic [DMEM_BE_W-1:0]   be;
    logic                   is_write;
    logic                   err;
  } dm_req_t;

  function automatic logic addr_misaligned(input logic [DMEM_ADDR_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_ram_be.sv
// Word-organised RAM with per-byte write enables: synchronous write, combinational read.
module dmem_ram_be #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned DATA_W      = 32,
  localparam int unsigned IdxW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1,
  localparam int unsigned BeW        = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IdxW-1:0]   waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [BeW-1:0]    be_i,
  input  logic [IdxW-1:0]   raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  // Contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned b = 0; b < BeW; b++) begin
        if (be_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Data-port memory responder: accepts one request, waits WAIT_CYCLES, answers with a one-cycle pulse.
// Define DMEM_TOHOST_EN to decode a tohost mailbox word at TOHOST_ADDR.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned       ADDR_W      = DMEM_ADDR_W,
  parameter int unsigned       DATA_W      = DMEM_DATA_W,
  parameter int unsigned       DEPTH_WORDS = 1024,
  parameter int unsigned       WAIT_CYCLES = 1,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(100)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [3:0]        req_be_i,
  input  logic              mem_write_i,
  input  logic              mem_read_i,
  output logic              req_ready_o,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              tohost_valid_o,
  output logic [DATA_W-1:0] tohost_data_o
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

`ifdef DMEM_TOHOST_EN
  localparam bit TohostEn = 1'b1;
`else
  localparam bit TohostEn = 1'b0;
`endif

  dm_state_t   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  dm_req_t     req_q, req_d;

  logic        accept;
  logic [31:0] word_ext;
  logic        out_of_range;
  logic        addr_is_tohost;
  logic        req_err;
  logic        rsp_fire;
  logic        tohost_hit;
  logic        ram_we;
  logic [DATA_W-1:0] ram_rdata;

  assign accept         = (state_q == DM_IDLE) && (mem_write_i || mem_read_i);
  assign word_ext       = 32'(req_addr_i[ADDR_W-1:2]);
  assign out_of_range   = word_ext >= DEPTH_WORDS;
  assign addr_is_tohost = (req_addr_i == TOHOST_ADDR);

  // Only full-word stores may update the mailbox; partial ones are rejected.
  assign req_err = addr_misaligned(req_addr_i) || out_of_range ||
                   (mem_write_i && mem_read_i) ||
                   (TohostEn && mem_write_i && addr_is_tohost && (req_be_i != 4'hF));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    unique case (state_q)
      DM_IDLE: begin
        if (accept) begin
          req_d.addr     = req_addr_i;
          req_d.wdata    = req_wdata_i;
          req_d.be       = req_be_i;
          req_d.is_write = mem_write_i;
          req_d.err      = req_err;
          if (WAIT_CYCLES == 0) begin
            state_d = DM_RESP;
          end else begin
            state_d = DM_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      DM_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = DM_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DM_RESP: begin
        state_d = DM_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = DM_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= DM_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  assign rsp_fire   = (state_q == DM_RESP);
  assign tohost_hit = TohostEn && req_q.is_write && (req_q.addr == TOHOST_ADDR);
  // The store lands on the edge that leaves RESP, so a reset before then drops it.
  assign ram_we     = rsp_fire && req_q.is_write && !req_q.err && !tohost_hit;

  dmem_ram_be #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .DATA_W      (DATA_W)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (req_q.addr[IdxW+1:2]),
    .wdata_i (req_q.wdata),
    .be_i    (req_q.be),
    .raddr_i (req_q.addr[IdxW+1:2]),
    .rdata_o (ram_rdata)
  );

  assign req_ready_o = (state_q == DM_IDLE);
  assign rsp_valid_o = rsp_fire;
  assign rsp_err_o   = rsp_fire && req_q.err;
  assign rsp_rdata_o = (rsp_fire && !req_q.is_write && !req_q.err) ? ram_rdata : '0;

`ifdef DMEM_TOHOST_EN
  logic              tohost_valid_q;
  logic [DATA_W-1:0] tohost_data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tohost_valid_q <= 1'b0;
      tohost_data_q  <= '0;
    end else if (rsp_fire && tohost_hit && !req_q.err) begin
      tohost_valid_q <= 1'b1;
      tohost_data_q  <= req_q.wdata;
    end
  end

  assign tohost_valid_o = tohost_valid_q;
  assign tohost_data_o  = tohost_data_q;
`else
  assign tohost_valid_o = 1'b0;
  assign tohost_data_o  = '0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with one wait state, one with none, scoreboard-checked.
module tb_data_mem_responder;

  localparam int unsigned Depth = 1024;
`ifdef DMEM_TOHOST_EN
  localparam bit ThEn = 1'b1;
`else
  localparam bit ThEn = 1'b0;
`endif

  logic        clk, rst_n;
  logic [19:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        wr, rd, sel;

  logic        ready1, valid1, err1, thv1, ready0, valid0, err0, thv0;
  logic [31:0] rdata1, thd1, rdata0, thd0;
  logic        ready, rsp_valid, rsp_err, th_valid;
  logic [31:0] rsp_rdata, th_data;

  // sel=0 drives the one-wait-state instance, sel=1 the zero-wait-state one.
  assign ready     = sel ? ready0 : ready1;
  assign rsp_valid = sel ? valid0 : valid1;
  assign rsp_err   = sel ? err0   : err1;
  assign rsp_rdata = sel ? rdata0 : rdata1;
  assign th_valid  = sel ? thv0   : thv1;
  assign th_data   = sel ? thd0   : thd1;

  data_mem_responder #(.WAIT_CYCLES(1)) u_dut1 (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_addr_i     (addr),
    .req_wdata_i    (wdata),
    .req_be_i       (be),
    .mem_write_i    (wr & ~sel),
    .mem_read_i     (rd & ~sel),
    .req_ready_o    (ready1),
    .rsp_valid_o    (valid1),
    .rsp_rdata_o    (rdata1),
    .rsp_err_o      (err1),
    .tohost_valid_o (thv1),
    .tohost_data_o  (thd1)
  );

  data_mem_responder #(.WAIT_CYCLES(0)) u_dut0 (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_addr_i     (addr),
    .req_wdata_i    (wdata),
    .req_be_i       (be),
    .mem_write_i    (wr & sel),
    .mem_read_i     (rd & sel),
    .req_ready_o    (ready0),
    .rsp_valid_o    (valid0),
    .rsp_rdata_o    (rdata0),
    .rsp_err_o      (err0),
    .tohost_valid_o (thv0),
    .tohost_data_o  (thd0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    bit          chk_data;
  } exp_t;

  exp_t        sb[$];
  int          vectors;
  int          miscompares;
  logic [31:0] ref_mem [2][Depth];
  bit          known   [2][Depth];
  logic        exp_thv [2];
  logic [31:0] exp_thd [2];

  logic        obs_got, obs_extra, obs_err;
  int          obs_lat;
  logic [31:0] obs_rdata;
  exp_t        e;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  task automatic do_req(input logic w, input logic r, input logic [19:0] a,
                        input logic [31:0] d, input logic [3:0] b);
    int n;
    obs_got = 1'b0; obs_extra = 1'b0; obs_lat = 0; obs_err = 1'b0; obs_rdata = '0;
    @(negedge clk);
    addr = a; wdata = d; be = b; wr = w; rd = r;
    n = 0;
    while (!ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      wr = 1'b0; rd = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    // Scramble the request lines so a responder that fails to latch them shows up.
    wr = 1'b0; rd = 1'b0; addr = 20'($urandom); wdata = $urandom; be = 4'($urandom);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        obs_got = 1'b1; obs_lat = i; obs_rdata = rsp_rdata; obs_err = rsp_err;
        break;
      end
    end
    if (obs_got) begin
      @(negedge clk);
      obs_extra = rsp_valid;
    end
  endtask

  // Reference model: derive the expected response, push it, then drive the request.
  task automatic run_one(input string name, input logic w, input logic r, input logic [19:0] a,
                         input logic [31:0] d, input logic [3:0] b);
    exp_t        x;
    bit          mi;
    int unsigned word;
    logic [9:0]  idx;
    logic        x_err;
    mi    = sel;
    word  = 32'(a[19:2]);
    idx   = word[9:0];
    x_err = (a[1:0] != 2'b00) || (word >= Depth) || (w && r) ||
            (ThEn && w && (a == 20'd100) && (b != 4'hF));
    x.name = name; x.lat = sel ? 1 : 2; x.err = x_err; x.rdata = '0; x.chk_data = 1'b1;
    if (!x_err && w) begin
      if (ThEn && (a == 20'd100)) begin
        exp_thv[mi] = 1'b1;
        exp_thd[mi] = d;
      end else begin
        ref_mem[mi][idx] = merge(ref_mem[mi][idx], d, b);
        if (b == 4'hF) known[mi][idx] = 1'b1;
      end
    end else if (!x_err) begin
      x.rdata    = ref_mem[mi][idx];
      x.chk_data = known[mi][idx];
    end
    sb.push_back(x);
    do_req(w, r, a, d, b);
  endtask

  task automatic test_reset();
    logic saw;
    rst_n = 1'b0; sel = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0; be = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      #1;
      vectors++;
      if ({ready, rsp_valid, rsp_rdata, rsp_err, th_valid, th_data} !==
          {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
        miscompares++;
        $display("FAIL reset_state dut%0d: ready=%b valid=%b rdata=%h err=%b thv=%b thd=%h, want 1 0 0 0 0 0",
                 s, ready, rsp_valid, rsp_rdata, rsp_err, th_valid, th_data);
      end
    end
    @(negedge clk);
    rst_n = 1'b1; sel = 1'b0;

    run_one("rst_seed_write", 1'b1, 1'b0, 20'h60, 32'h0BAD_F00D, 4'hF);
    e = sb.pop_front(); vectors++;
    if (!obs_got || obs_extra || obs_lat != e.lat || obs_err !== e.err ||
        (e.chk_data && obs_rdata !== e.rdata)) begin
      miscompares++;
      $display("FAIL %s: got=%0b lat=%0d extra=%0b err=%0b rdata=%08h, want lat=%0d err=%0b rdata=%08h",
               e.name, obs_got, obs_lat, obs_extra, obs_err, obs_rdata, e.lat, e.err, e.rdata);
    end

    @(negedge clk);
    addr = 20'h60; wdata = 32'hDEAD_BEEF; be = 4'hF; wr = 1'b1;
    @(posedge clk);
    #1 wr = 1'b0;
    @(negedge clk);
    vectors++;
    if ({ready, rsp_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_in_wait: ready=%b valid=%b, want 0 0", ready, rsp_valid);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ready, rsp_valid, rsp_rdata, rsp_err, th_valid, th_data} !==
        {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL rst_async: ready=%b valid=%b rdata=%h err=%b thv=%b thd=%h, want 1 0 0 0 0 0",
               ready, rsp_valid, rsp_rdata, rsp_err, th_valid, th_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) saw = 1'b1;
    end
    vectors++;
    if (saw !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_no_rsp: aborted write produced rsp_valid=%b, want 0", saw);
    end

    run_one("rst_read_back", 1'b0, 1'b1, 20'h60, 32'h0, 4'h0);
    e = sb.pop_front(); vectors++;
    if (!obs_got || obs_extra || obs_lat != e.lat || obs_err !== e.err ||
        (e.chk_data && obs_rdata !== e.rdata)) begin
      miscompares++;
      $display("FAIL %s: got=%0b lat=%0d extra=%0b err=%0b rdata=%08h, want lat=%0d err=%0b rdata=%08h",
               e.name, obs_got, obs_lat, obs_extra, obs_err, obs_rdata, e.lat, e.err, e.rdata);
    end
  endtask

  // Table-driven sequence on the currently selected instance.
  task automatic run_table(input string tag, input logic tw[], input logic tr[],
                           input logic [19:0] ta[], input logic [31:0] td[], input logic [3:0] tb[]);
    for (int i = 0; i < ta.size(); i++) begin
      run_one($sformatf("%s_%0d", tag, i), tw[i], tr[i], ta[i], td[i], tb[i]);
      e = sb.pop_front(); vectors++;
      if (!obs_got || obs_extra || obs_lat != e.lat || obs_err !== e.err ||
          (e.chk_data && obs_rdata !== e.rdata)) begin
        miscompares++;
        $display("FAIL %s: got=%0b lat=%0d extra=%0b err=%0b rdata=%08h, want lat=%0d err=%0b rdata=%08h",
                 e.name, obs_got, obs_lat, obs_extra, obs_err, obs_rdata, e.lat, e.err, e.rdata);
      end
    end
  endtask

  task automatic test_basic();
    logic        tw[] = '{1'b1, 1'b0};
    logic        tr[] = '{1'b0, 1'b1};
    logic [19:0] ta[] = '{20'h60, 20'h60};
    logic [31:0] td[] = '{32'h1234_5678, 32'h0};
    logic [3:0]  tb[] = '{4'hF, 4'h0};
    sel = 1'b0;
    run_table("basic", tw, tr, ta, td, tb);
  endtask

  task automatic test_byte_lanes();
    logic        tw[] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        tr[] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [19:0] ta[] = '{20'h10, 20'h10, 20'h10, 20'h10, 20'h10};
    logic [31:0] td[] = '{32'hFFFF_FFFF, 32'h0000_00AA, 32'h0, 32'h1122_3344, 32'h0};
    logic [3:0]  tb[] = '{4'hF, 4'b0001, 4'h0, 4'b1010, 4'h0};
    sel = 1'b0;
    run_table("lanes", tw, tr, ta, td, tb);
  endtask

  task automatic test_errors();
    logic        tw[] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        tr[] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [19:0] ta[] = '{20'h0, 20'h60, 20'h62, 20'h1000, 20'h0, 20'h61, 20'h60, 20'h60,
                          20'hFFC, 20'hFFC, 20'hFFFFC};
    logic [31:0] td[] = '{32'h0000_0C0C, 32'h5555_5555, 32'h0, 32'hBAD0_0001, 32'h0,
                          32'hBAD0_0002, 32'hBAD0_0003, 32'h0, 32'hCAFE_F00D, 32'h0, 32'h0};
    logic [3:0]  tb[] = '{4'hF, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0};
    sel = 1'b0;
    run_table("err", tw, tr, ta, td, tb);
  endtask

  task automatic test_tohost();
    logic        tw[] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic        tr[] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [19:0] ta[] = '{20'd96, 20'd100, 20'd100, 20'd100};
    logic [31:0] td[] = '{32'h0000_1111, 32'd25, 32'h0000_0077, 32'h0};
    logic [3:0]  tb[] = '{4'hF, 4'hF, 4'b0001, 4'h0};
    sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run_one($sformatf("tohost_%0d", i), tw[i], tr[i], ta[i], td[i], tb[i]);
      e = sb.pop_front(); vectors++;
      if (!obs_got || obs_extra || obs_lat != e.lat || obs_err !== e.err ||
          (e.chk_data && obs_rdata !== e.rdata)) begin
        miscompares++;
        $display("FAIL %s: got=%0b lat=%0d extra=%0b err=%0b rdata=%08h, want lat=%0d err=%0b rdata=%08h",
                 e.name, obs_got, obs_lat, obs_extra, obs_err, obs_rdata, e.lat, e.err, e.rdata);
      end
      vectors++;
      if ({th_valid, th_data} !== {exp_thv[0], exp_thd[0]}) begin
        miscompares++;
        $display("FAIL tohost_mbox_%0d: thv=%b thd=%08h, want thv=%b thd=%08h",
                 i, th_valid, th_data, exp_thv[0], exp_thd[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned word;
    logic [19:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    sel = 1'b1;
    for (int n = 0; n < 100; n++) begin
      word = $urandom_range(32, Depth - 1);
      a    = 20'(word << 2);
      d    = $urandom;
      b    = known[1][word[9:0]] ? 4'($urandom_range(1, 15)) : 4'hF;
      for (int k = 0; k < 2; k++) begin
        run_one($sformatf("b2b_%0d_%s", n, (k == 0) ? "wr" : "rd"), k == 0, k == 1, a, d, b);
        e = sb.pop_front(); vectors++;
        if (!obs_got || obs_extra || obs_lat != e.lat || obs_err !== e.err ||
            (e.chk_data && obs_rdata !== e.rdata)) begin
          miscompares++;
          $display("FAIL %s: got=%0b lat=%0d extra=%0b err=%0b rdata=%08h, want lat=%0d err=%0b rdata=%08h",
                   e.name, obs_got, obs_lat, obs_extra, obs_err, obs_rdata, e.lat, e.err, e.rdata);
        end
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int m = 0; m < 2; m++) begin
      exp_thv[m] = 1'b0;
      exp_thd[m] = '0;
      for (int w = 0; w < Depth; w++) begin
        known[m][w]   = 1'b0;
        ref_mem[m][w] = '0;
      end
    end
    test_reset();
    test_basic();
    test_byte_lanes();
    test_errors();
    test_tohost();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1);
  end

endmodule
